// File: rtl/imem_loader.sv
// Runtime program loader: packs a valid/ready byte stream into 16-bit words
// (high byte first), writes them into a 512x16 instruction memory and serves CPU fetch reads.
module imem_loader #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic [15:0] fetch_addr,
  output logic [15:0] fetch_instr,
  output logic [9:0]  word_count,
  output logic        cpu_run,
  output logic        overflow
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    LOAD_HI = 2'd0,
    LOAD_LO = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_hi_byte;
  logic [7:0]          w_hi_nxt;
  logic [CNT_W-1:0]    r_word_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic                r_overflow;
  logic                w_ovf_nxt;
  logic                r_in_ready;
  logic                r_cpu_run;
  logic                w_accept;
  logic                w_full;
  logic                w_we;
  logic [WORD_W-1:0]   w_wdata;
  logic [ADDR_W-1:0]   w_waddr;
  logic [WORD_W-1:0]   r_mem [DEPTH];

  assign w_accept = in_valid & r_in_ready;
  assign w_full   = (r_word_count == CNT_W'(DEPTH));
  assign w_waddr  = r_word_count[ADDR_W-1:0];

  // Next-state, word assembly and memory write strobe
  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi_byte;
    w_count_nxt = r_word_count;
    w_ovf_nxt   = r_overflow;
    w_we        = 1'b0;
    w_wdata     = '0;
    case (r_state)
      LOAD_HI: begin
        if (w_accept) begin
          if (w_full) begin
            // Memory full: byte is dropped, only the end-of-program marker still counts
            w_ovf_nxt = 1'b1;
            if (in_last) w_state_nxt = DONE;
          end else if (in_last) begin
            w_we        = 1'b1;
            w_wdata     = {in_data, 8'h00};
            w_count_nxt = r_word_count + CNT_W'(1);
            w_state_nxt = DONE;
          end else begin
            w_hi_nxt    = in_data;
            w_state_nxt = LOAD_LO;
          end
        end
      end
      LOAD_LO: begin
        if (w_accept) begin
          w_we        = 1'b1;
          w_wdata     = {r_hi_byte, in_data};
          w_count_nxt = r_word_count + CNT_W'(1);
          w_state_nxt = in_last ? DONE : LOAD_HI;
        end
      end
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = LOAD_HI;
    endcase
  end

  // State and registered outputs, updated on the CPU's negative edge
  always_ff @(negedge clock) begin
    if (reset) begin
      r_state      <= LOAD_HI;
      r_hi_byte    <= 8'h00;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_in_ready   <= 1'b1;
      r_cpu_run    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hi_byte    <= w_hi_nxt;
      r_word_count <= w_count_nxt;
      r_overflow   <= w_ovf_nxt;
      r_in_ready   <= (w_state_nxt != DONE);
      r_cpu_run    <= (w_state_nxt == DONE);
    end
  end

  // Instruction memory is intentionally not cleared by reset
  always_ff @(negedge clock) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign fetch_instr = (fetch_addr < 16'(DEPTH)) ? r_mem[fetch_addr[ADDR_W-1:0]] : 16'h0000;
  assign in_ready    = r_in_ready;
  assign word_count  = r_word_count;
  assign cpu_run     = r_cpu_run;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed vector table, reset/overflow/fetch
// corner sequences and randomized streams checked against a byte-stream model.
module tb_imem_loader;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [15:0] fetch_addr;
  logic [15:0] fetch_instr;
  logic [9:0]  word_count;
  logic        cpu_run;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  imem_loader dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .fetch_addr (fetch_addr),
    .fetch_instr(fetch_instr),
    .word_count (word_count),
    .cpu_run    (cpu_run),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [47:0] bytes;
    logic [3:0]  n;
    logic        gaps;
    logic [47:0] words;
    logic [9:0]  cnt;
  } vec_t;

  vec_t vecs [4];
  logic [7:0] q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    @(posedge clock);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic read_word(input int addr, output logic [15:0] d);
    fetch_addr = 16'(addr);
    #1;
    d = fetch_instr;
  endtask

  // Model: words written after k accepted bytes, fin = last byte was marked in_last
  function automatic int exp_count(input int k, input bit fin);
    int c;
    c = k / 2;
    if (fin && (k % 2 == 1)) c++;
    if (c > 512) c = 512;
    return c;
  endfunction

  function automatic logic [15:0] exp_word(input int i);
    logic [7:0] lo;
    lo = (2 * i + 1 < q.size()) ? q[2 * i + 1] : 8'h00;
    return {q[2 * i], lo};
  endfunction

  // Streams q, checking word_count after each byte; ends with in_last on the final byte
  task automatic stream_q(input string nm, input int max_gap);
    for (int k = 0; k < q.size(); k++) begin
      bit fin;
      fin = (k == q.size() - 1);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send(q[k], fin);
      chk({nm, "_cnt"}, 32'(word_count), 32'(exp_count(k + 1, fin)));
      chk({nm, "_run"}, 32'(cpu_run), 32'(fin));
    end
  endtask

  task automatic check_words(input string nm, input int cnt);
    logic [15:0] d;
    for (int i = 0; i < cnt; i++) begin
      read_word(i, d);
      chk({nm, "_mem"}, 32'(d), 32'(exp_word(i)));
    end
  endtask

  initial begin
    logic [15:0] d;
    logic [47:0] tmp;
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_last    = 1'b0;
    fetch_addr = 16'h0000;

    vecs[0] = '{bytes: 48'h123456789ABC, n: 4'd6, gaps: 1'b0, words: 48'h123456789ABC, cnt: 10'd3};
    vecs[1] = '{bytes: 48'hA1B2C3000000, n: 4'd3, gaps: 1'b0, words: 48'hA1B2C3000000, cnt: 10'd2};
    vecs[2] = '{bytes: 48'h112233440000, n: 4'd4, gaps: 1'b1, words: 48'h112233440000, cnt: 10'd2};
    vecs[3] = '{bytes: 48'h7F0000000000, n: 4'd1, gaps: 1'b0, words: 48'h7F0000000000, cnt: 10'd1};

    // Reset state
    do_reset();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_cnt",   32'(word_count), 32'd0);
    chk("rst_run",   32'(cpu_run), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);

    // Directed vector table
    for (int v = 0; v < 4; v++) begin
      do_reset();
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        bit fin;
        tmp = vecs[v].bytes;
        fin = (i == int'(vecs[v].n) - 1);
        if (vecs[v].gaps) idle($urandom_range(1, 3));
        send(tmp[47 - 8 * i -: 8], fin);
        chk("vec_run", 32'(cpu_run), 32'(fin));
      end
      chk("vec_cnt",   32'(word_count), 32'(vecs[v].cnt));
      chk("vec_ready", 32'(in_ready), 32'd0);
      chk("vec_ovf",   32'(overflow), 32'd0);
      for (int i = 0; i < int'(vecs[v].cnt); i++) begin
        tmp = vecs[v].words;
        read_word(i, d);
        chk("vec_mem", 32'(d), 32'(tmp[47 - 16 * i -: 16]));
      end
      // DONE ignores further traffic
      send(8'hEE, 1'b0);
      chk("done_cnt", 32'(word_count), 32'(vecs[v].cnt));
      chk("done_run", 32'(cpu_run), 32'd1);
    end

    // Reset mid-load discards the pending high byte
    do_reset();
    send(8'hDE, 1'b0);
    do_reset();
    chk("mid_ready", 32'(in_ready), 32'd1);
    chk("mid_cnt0",  32'(word_count), 32'd0);
    send(8'hAB, 1'b0);
    send(8'hCD, 1'b1);
    chk("mid_cnt", 32'(word_count), 32'd1);
    read_word(0, d);
    chk("mid_mem0", 32'(d), 32'h0000ABCD);

    // in_last without in_valid is ignored
    do_reset();
    @(posedge clock);
    in_last = 1'b1;
    @(negedge clock);
    #1;
    in_last = 1'b0;
    chk("lastnv_run",   32'(cpu_run), 32'd0);
    chk("lastnv_ready", 32'(in_ready), 32'd1);
    send(8'h12, 1'b0);
    send(8'h34, 1'b1);

    // Fetch range: in range, just past DEPTH (no aliasing), and far out of range
    read_word(0, d);
    chk("fetch_0", 32'(d), 32'h00001234);
    read_word(512, d);
    chk("fetch_512", 32'(d), 32'h00000000);
    read_word(600, d);
    chk("fetch_600", 32'(d), 32'h00000000);

    // Full memory: 1026 bytes, the 1025th overflows and is dropped
    do_reset();
    q.delete();
    for (int k = 0; k < 1026; k++) q.push_back(8'($urandom));
    for (int k = 0; k < 1026; k++) begin
      send(q[k], k == 1025);
      if (k == 1023) begin
        chk("full_cnt",   32'(word_count), 32'd512);
        chk("full_ovf0",  32'(overflow), 32'd0);
        chk("full_ready", 32'(in_ready), 32'd1);
      end
      if (k == 1024) begin
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(word_count), 32'd512);
        chk("ovf_run", 32'(cpu_run), 32'd0);
      end
    end
    chk("ovf_end_cnt", 32'(word_count), 32'd512);
    chk("ovf_end_ovf", 32'(overflow), 32'd1);
    chk("ovf_end_run", 32'(cpu_run), 32'd1);
    chk("ovf_end_rdy", 32'(in_ready), 32'd0);
    check_words("full", 512);

    // Randomized streams with random idle gaps
    for (int r = 0; r < 10; r++) begin
      int n;
      do_reset();
      q.delete();
      n = $urandom_range(1, 40);
      for (int k = 0; k < n; k++) q.push_back(8'($urandom));
      stream_q("rnd", 3);
      chk("rnd_ready", 32'(in_ready), 32'd0);
      chk("rnd_ovf",   32'(overflow), 32'd0);
      check_words("rnd", exp_count(n, 1'b1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
